// File: rtl/vm_arb_pkg.sv
// vm_arb_pkg: shared types and constants for the vending transaction arbiter.
//   state_t        - controller FSM states
//   STAT_*         - usr_status response codes
//   DEF_NUM_ITEMS  - default number of item slots (codes 1..NUM_ITEMS)
//   DEF_CNT_W      - default width of a per-item stock count
//   item_valid()   - true when an item code addresses a real slot
package vm_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUP_WR,
    USR_CHK,
    USR_VEND,
    USR_RSP
  } state_t;

  localparam logic [1:0] STAT_INVALID   = 2'b00;
  localparam logic [1:0] STAT_SOLD_OUT  = 2'b01;
  localparam logic [1:0] STAT_NO_CREDIT = 2'b10;
  localparam logic [1:0] STAT_VENDED    = 2'b11;

  localparam int unsigned DEF_NUM_ITEMS = 6;
  localparam int unsigned DEF_CNT_W     = 4;

  function automatic logic item_valid(input logic [2:0] item, input int unsigned num_items);
    return (item != 3'd0) && (32'(item) <= num_items);
  endfunction

endpackage

// File: rtl/vm_item_table.sv
// vm_item_table: per-item stock count and unit cost storage.
//   clk, rst            - clock; synchronous active-low clear of every entry
//   wr_en/wr_item/
//   wr_count/wr_cost    - write port; invalid item codes are ignored
//   dec_en/dec_item     - decrement port; never takes a count below zero
//   rd_item/rd_count/
//   rd_cost             - combinational read port; invalid codes read as 0
module vm_item_table
  import vm_arb_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = DEF_NUM_ITEMS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_item,
  input  logic [CNT_W-1:0] wr_count,
  input  logic [7:0]       wr_cost,
  input  logic             dec_en,
  input  logic [2:0]       dec_item,
  input  logic [2:0]       rd_item,
  output logic [CNT_W-1:0] rd_count,
  output logic [7:0]       rd_cost
);

  // Indexed directly by the 3-bit item code; slot 0 and slots above
  // NUM_ITEMS are never written and stay at their cleared value.
  logic [CNT_W-1:0] count_q [8];
  logic [7:0]       cost_q  [8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        count_q[i] <= '0;
        cost_q[i]  <= '0;
      end
    end else begin
      if (wr_en && item_valid(wr_item, NUM_ITEMS)) begin
        count_q[wr_item] <= wr_count;
        cost_q[wr_item]  <= wr_cost;
      end
      if (dec_en && item_valid(dec_item, NUM_ITEMS) && (count_q[dec_item] != '0)) begin
        count_q[dec_item] <= count_q[dec_item] - 1'b1;
      end
    end
  end

  assign rd_count = item_valid(rd_item, NUM_ITEMS) ? count_q[rd_item] : '0;
  assign rd_cost  = item_valid(rd_item, NUM_ITEMS) ? cost_q[rd_item]  : '0;

endmodule

// File: rtl/vm_txn_arbiter.sv
// vm_txn_arbiter: arbitrates supplier restocks and user purchases onto a
// shared item table and runs one transaction at a time.
//   clk, rst                 - clock; synchronous active-low reset
//   sup_req/sup_item/
//   sup_count/sup_cost       - supplier restock request (held until sup_ack)
//   sup_ack                  - one-cycle pulse when the restock is written
//   usr_req/usr_item/
//   usr_credit               - user purchase request (held until usr_ack)
//   usr_ack                  - one-cycle pulse when the purchase is resolved
//   usr_status               - 11 vended, 01 sold out, 10 no credit, 00 invalid
//   vend_item/change         - nonzero only during a vend ack
//   busy                     - high whenever the FSM is not in IDLE
// Build option: define VM_ARB_RR_EN for round-robin tie-breaking;
// otherwise the supplier always wins a tie.
module vm_txn_arbiter
  import vm_arb_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = DEF_NUM_ITEMS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sup_req,
  input  logic [2:0]       sup_item,
  input  logic [CNT_W-1:0] sup_count,
  input  logic [7:0]       sup_cost,
  output logic             sup_ack,
  input  logic             usr_req,
  input  logic [2:0]       usr_item,
  input  logic [7:0]       usr_credit,
  output logic             usr_ack,
  output logic [1:0]       usr_status,
  output logic [2:0]       vend_item,
  output logic [7:0]       change,
  output logic             busy
);

  state_t           state, state_d;
  logic [2:0]       item_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       cost_q;
  logic [7:0]       credit_q;

  logic             sup_ack_d, usr_ack_d;
  logic [1:0]       status_d, chk_status;
  logic [2:0]       vend_d;
  logic [7:0]       change_d;
  logic             wr_en, dec_en;
  logic [CNT_W-1:0] rd_count;
  logic [7:0]       rd_cost;
  logic             can_grant, sup_win, grant_sup, grant_usr;

  // The ack cycle is spent back in IDLE with the requester still holding its
  // request; grants wait one cycle so that request is not served twice.
  assign can_grant = (state == IDLE) && !sup_ack && !usr_ack;

`ifdef VM_ARB_RR_EN
  logic last_usr;  // last-winner flag: 1 = user won the most recent grant

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_usr <= 1'b1;
    end else if (grant_sup) begin
      last_usr <= 1'b0;
    end else if (grant_usr) begin
      last_usr <= 1'b1;
    end
  end

  assign sup_win = sup_req && (!usr_req || last_usr);
`else
  assign sup_win = sup_req;
`endif

  assign grant_sup = can_grant && sup_win;
  assign grant_usr = can_grant && usr_req && !sup_win;
  assign busy      = (state != IDLE);

  vm_item_table #(
    .NUM_ITEMS (NUM_ITEMS),
    .CNT_W     (CNT_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_item  (item_q),
    .wr_count (cnt_q),
    .wr_cost  (cost_q),
    .dec_en   (dec_en),
    .dec_item (item_q),
    .rd_item  (item_q),
    .rd_count (rd_count),
    .rd_cost  (rd_cost)
  );

  always_comb begin
    if (!item_valid(item_q, NUM_ITEMS)) begin
      chk_status = STAT_INVALID;
    end else if (rd_count == '0) begin
      chk_status = STAT_SOLD_OUT;
    end else if (credit_q < rd_cost) begin
      chk_status = STAT_NO_CREDIT;
    end else begin
      chk_status = STAT_VENDED;
    end
  end

  always_comb begin
    state_d   = state;
    sup_ack_d = 1'b0;
    usr_ack_d = 1'b0;
    status_d  = usr_status;
    vend_d    = '0;
    change_d  = '0;
    wr_en     = 1'b0;
    dec_en    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_sup) begin
          state_d = SUP_WR;
        end else if (grant_usr) begin
          state_d = USR_CHK;
        end
      end
      SUP_WR: begin
        wr_en     = 1'b1;
        sup_ack_d = 1'b1;
        state_d   = IDLE;
      end
      USR_CHK: begin
        state_d = (chk_status == STAT_VENDED) ? USR_VEND : USR_RSP;
      end
      USR_VEND: begin
        dec_en    = 1'b1;
        usr_ack_d = 1'b1;
        status_d  = STAT_VENDED;
        vend_d    = item_q;
        change_d  = credit_q - rd_cost;
        state_d   = IDLE;
      end
      USR_RSP: begin
        usr_ack_d = 1'b1;
        status_d  = chk_status;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sup_ack    <= 1'b0;
      usr_ack    <= 1'b0;
      usr_status <= STAT_INVALID;
      vend_item  <= '0;
      change     <= '0;
    end else begin
      state      <= state_d;
      sup_ack    <= sup_ack_d;
      usr_ack    <= usr_ack_d;
      usr_status <= status_d;
      vend_item  <= vend_d;
      change     <= change_d;
    end
  end

  // Request fields are captured only on the grant edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      item_q   <= '0;
      cnt_q    <= '0;
      cost_q   <= '0;
      credit_q <= '0;
    end else if (grant_sup) begin
      item_q <= sup_item;
      cnt_q  <= sup_count;
      cost_q <= sup_cost;
    end else if (grant_usr) begin
      item_q   <= usr_item;
      credit_q <= usr_credit;
    end
  end

endmodule

// File: tb/tb_vm_txn_arbiter.sv
module tb_vm_txn_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sup_req;
  logic [2:0] sup_item;
  logic [3:0] sup_count;
  logic [7:0] sup_cost;
  logic       sup_ack;
  logic       usr_req;
  logic [2:0] usr_item;
  logic [7:0] usr_credit;
  logic       usr_ack;
  logic [1:0] usr_status;
  logic [2:0] vend_item;
  logic [7:0] change;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef VM_ARB_RR_EN
  localparam int TIE2_WINNER = 2;
`else
  localparam int TIE2_WINNER = 1;
`endif

  vm_txn_arbiter #(.NUM_ITEMS(6), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sup_req    (sup_req),
    .sup_item   (sup_item),
    .sup_count  (sup_count),
    .sup_cost   (sup_cost),
    .sup_ack    (sup_ack),
    .usr_req    (usr_req),
    .usr_item   (usr_item),
    .usr_credit (usr_credit),
    .usr_ack    (usr_ack),
    .usr_status (usr_status),
    .vend_item  (vend_item),
    .change     (change),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [2:0] vend;
    logic [7:0] chg;
  } sb_t;

  typedef struct {
    bit         is_sup;
    logic [2:0] item;
    logic [3:0] cnt;
    logic [7:0] val;   // cost for a restock, credit for a purchase
    logic [1:0] es;
    logic [2:0] ev;
    logic [7:0] ec;
  } vec_t;

  sb_t        sb[$];
  sb_t        mon_e;
  logic [1:0] last_st = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every usr_ack and checks the
  // idle-time behaviour of the response outputs otherwise.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      last_st = 2'b00;
    end else if (usr_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("usr_status", int'(usr_status), int'(mon_e.st));
        chk("vend_item", int'(vend_item), int'(mon_e.vend));
        chk("change", int'(change), int'(mon_e.chg));
      end
      last_st = usr_status;
    end else begin
      chk("status_hold", int'(usr_status), int'(last_st));
      chk("vend_idle", int'(vend_item), 0);
      chk("change_idle", int'(change), 0);
    end
  end

  task automatic do_sup(input logic [2:0] item, input logic [3:0] cnt, input logic [7:0] cost);
    int n;
    bit got;
    @(posedge clk); #1;
    sup_item = item; sup_count = cnt; sup_cost = cost; sup_req = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("sup_busy", int'(busy), 1);
      if (sup_ack) got = 1;
    end
    sup_req = 1'b0;
    chk("sup_lat", got ? n : -1, 2);
    @(posedge clk); #1;
    chk("sup_ack_pulse", int'(sup_ack), 0);
  endtask

  task automatic do_usr(input logic [2:0] item, input logic [7:0] credit,
                        input logic [1:0] es, input logic [2:0] ev, input logic [7:0] ec);
    int n;
    bit got;
    sb_t e;
    e.st = es; e.vend = ev; e.chg = ec;
    sb.push_back(e);
    @(posedge clk); #1;
    usr_item = item; usr_credit = credit; usr_req = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("usr_busy", int'(busy), 1);
      if (usr_ack) got = 1;
    end
    usr_req = 1'b0;
    chk("usr_lat", got ? n : -1, 3);
    @(posedge clk); #1;
    chk("usr_ack_pulse", int'(usr_ack), 0);
  endtask

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    int ua, sa, nack, n;
    int who[2];
    sb_t e;

    vecs[0]  = '{1'b1, 3'd2, 4'd3,  8'd25,  2'b00, 3'd0, 8'd0};
    vecs[1]  = '{1'b0, 3'd2, 4'd0,  8'd40,  2'b11, 3'd2, 8'd15};
    vecs[2]  = '{1'b0, 3'd2, 4'd0,  8'd10,  2'b10, 3'd0, 8'd0};
    vecs[3]  = '{1'b0, 3'd0, 4'd0,  8'd50,  2'b00, 3'd0, 8'd0};
    vecs[4]  = '{1'b0, 3'd4, 4'd0,  8'd50,  2'b01, 3'd0, 8'd0};
    vecs[5]  = '{1'b0, 3'd7, 4'd0,  8'd50,  2'b00, 3'd0, 8'd0};
    vecs[6]  = '{1'b1, 3'd7, 4'd5,  8'd1,   2'b00, 3'd0, 8'd0};
    vecs[7]  = '{1'b0, 3'd7, 4'd0,  8'd50,  2'b00, 3'd0, 8'd0};
    vecs[8]  = '{1'b0, 3'd2, 4'd0,  8'd25,  2'b11, 3'd2, 8'd0};
    vecs[9]  = '{1'b0, 3'd2, 4'd0,  8'd255, 2'b11, 3'd2, 8'd230};
    vecs[10] = '{1'b0, 3'd2, 4'd0,  8'd255, 2'b01, 3'd0, 8'd0};
    vecs[11] = '{1'b1, 3'd6, 4'd15, 8'd255, 2'b00, 3'd0, 8'd0};
    vecs[12] = '{1'b0, 3'd6, 4'd0,  8'd254, 2'b10, 3'd0, 8'd0};
    vecs[13] = '{1'b0, 3'd6, 4'd0,  8'd255, 2'b11, 3'd6, 8'd0};
    vecs[14] = '{1'b1, 3'd2, 4'd0,  8'd3,   2'b00, 3'd0, 8'd0};
    vecs[15] = '{1'b0, 3'd2, 4'd0,  8'd1,   2'b01, 3'd0, 8'd0};
    vecs[16] = '{1'b1, 3'd1, 4'd4,  8'd50,  2'b00, 3'd0, 8'd0};
    vecs[17] = '{1'b0, 3'd1, 4'd0,  8'd49,  2'b10, 3'd0, 8'd0};
    vecs[18] = '{1'b0, 3'd1, 4'd0,  8'd100, 2'b11, 3'd1, 8'd50};

    rst = 1'b0;
    sup_req = 1'b0; sup_item = '0; sup_count = '0; sup_cost = '0;
    usr_req = 1'b0; usr_item = '0; usr_credit = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sup_ack", int'(sup_ack), 0);
    chk("rst_usr_ack", int'(usr_ack), 0);
    chk("rst_status", int'(usr_status), 0);
    chk("rst_vend", int'(vend_item), 0);
    chk("rst_change", int'(change), 0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_sup) do_sup(vecs[i].item, vecs[i].cnt, vecs[i].val);
      else do_usr(vecs[i].item, vecs[i].val, vecs[i].es, vecs[i].ev, vecs[i].ec);
    end

    // Supplier raised while a purchase is in USR_CHK: table stays locked.
    do_sup(3'd5, 4'd2, 8'd10);
    e.st = 2'b11; e.vend = 3'd5; e.chg = 8'd0;
    sb.push_back(e);
    @(posedge clk); #1;
    usr_item = 3'd5; usr_credit = 8'd10; usr_req = 1'b1;
    @(posedge clk); #1;
    chk("lock_busy", int'(busy), 1);
    sup_item = 3'd5; sup_count = 4'd7; sup_cost = 8'd1; sup_req = 1'b1;
    ua = -1; sa = -1;
    for (int c = 1; c <= 20 && sa < 0; c++) begin
      @(posedge clk); #1;
      if (usr_ack) begin ua = c; usr_req = 1'b0; end
      if (sup_ack) begin sa = c; sup_req = 1'b0; end
    end
    chk("lock_usr_ack_cyc", ua, 2);
    chk("lock_sup_ack_cyc", sa, 5);
    @(posedge clk); #1;
    do_usr(3'd5, 8'd1, 2'b11, 3'd5, 8'd0);

    // Reset asserted while in USR_VEND: abandoned without ack, table cleared.
    do_sup(3'd3, 4'd1, 8'd5);
    @(posedge clk); #1;
    usr_item = 3'd3; usr_credit = 8'd9; usr_req = 1'b1;
    @(posedge clk); #1;
    chk("vrst_chk_busy", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("vrst_usr_ack", int'(usr_ack), 0);
    chk("vrst_sup_ack", int'(sup_ack), 0);
    chk("vrst_busy", int'(busy), 0);
    chk("vrst_status", int'(usr_status), 0);
    chk("vrst_vend", int'(vend_item), 0);
    chk("vrst_change", int'(change), 0);
    usr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_usr(3'd3, 8'd9, 2'b01, 3'd0, 8'd0);
    do_usr(3'd6, 8'd255, 2'b01, 3'd0, 8'd0);

    // Two ties back to back (first tie after reset); both use item 0.
    @(posedge clk); #1;
    sup_item = 3'd0; sup_count = 4'd1; sup_cost = 8'd1;
    usr_item = 3'd0; usr_credit = 8'd0;
    if (TIE2_WINNER == 2) begin
      e.st = 2'b00; e.vend = 3'd0; e.chg = 8'd0;
      sb.push_back(e);
    end
    sup_req = 1'b1; usr_req = 1'b1;
    nack = 0; n = 0;
    who[0] = 0; who[1] = 0;
    while (nack < 2 && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (sup_ack) begin who[nack] = 1; nack++; end
      else if (usr_ack) begin who[nack] = 2; nack++; end
    end
    sup_req = 1'b0; usr_req = 1'b0;
    chk("tie_acks", nack, 2);
    chk("tie_first", who[0], 1);
    chk("tie_second", who[1], TIE2_WINNER);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("end_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
